// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, variable-latency memory between instruction fetch
// and data load/store, with one transaction outstanding and a watchdog abort.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned ARB_MODE       = 0,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              insnReq,
   input  logic [ADDR_W-1:0] insnAddr,
   output logic [DATA_W-1:0] insnRdata,
   output logic              insnValid,
   output logic              insnStall,
   input  logic              dataReq,
   input  logic              dataWe,
   input  logic [ADDR_W-1:0] dataAddr,
   input  logic [DATA_W-1:0] dataWdata,
   output logic [DATA_W-1:0] dataRdata,
   output logic              dataValid,
   output logic              dataStall,
   output logic              memReq,
   output logic              memWe,
   output logic [ADDR_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWdata,
   input  logic [DATA_W-1:0] memRdata,
   input  logic              memAck,
   output logic              busError
);

   localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned LAST_VAL = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_VAL);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state;
   logic             last_data;
   logic [CNT_W-1:0] wd_cnt;
   logic             grant_d_c;
   logic             grant_i_c;
   logic             timeout_c;

   // Grant selection for the IDLE cycle; alternation flips away from the last grant.
   always_comb begin
      grant_d_c = 1'b0;
      grant_i_c = 1'b0;
      if (dataReq && insnReq) begin
         if (ARB_MODE == 0) grant_d_c = 1'b1;
         else               grant_d_c = !last_data;
         grant_i_c = !grant_d_c;
      end else begin
         grant_d_c = dataReq;
         grant_i_c = insnReq;
      end
   end

   // Fires in the TIMEOUT_CYCLES-th memReq cycle; an ack in that cycle takes precedence.
   assign timeout_c = (TIMEOUT_CYCLES != 0) && (wd_cnt == LAST_CNT);

   assign insnStall = insnReq && !insnValid;
   assign dataStall = dataReq && !dataValid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         last_data <= 1'b0;
         wd_cnt    <= '0;
         memReq    <= 1'b0;
         memWe     <= 1'b0;
         memAddr   <= '0;
         memWdata  <= '0;
         insnRdata <= '0;
         insnValid <= 1'b0;
         dataRdata <= '0;
         dataValid <= 1'b0;
         busError  <= 1'b0;
      end else begin
         insnValid <= 1'b0;
         dataValid <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d_c) begin
                  state     <= BUSY_D;
                  memReq    <= 1'b1;
                  memWe     <= dataWe;
                  memAddr   <= dataAddr;
                  memWdata  <= dataWdata;
                  last_data <= 1'b1;
                  wd_cnt    <= '0;
               end else if (grant_i_c) begin
                  state     <= BUSY_I;
                  memReq    <= 1'b1;
                  memWe     <= 1'b0;
                  memAddr   <= insnAddr;
                  memWdata  <= '0;
                  last_data <= 1'b0;
                  wd_cnt    <= '0;
               end
            end
            BUSY_I, BUSY_D: begin
               if (memAck) begin
                  state  <= DONE;
                  memReq <= 1'b0;
                  if (state == BUSY_I) begin
                     insnRdata <= memRdata;
                     insnValid <= 1'b1;
                  end else begin
                     dataRdata <= memWe ? '0 : memRdata;
                     dataValid <= 1'b1;
                  end
               end else if (timeout_c) begin
                  state    <= DONE;
                  memReq   <= 1'b0;
                  busError <= 1'b1;
                  if (state == BUSY_I) begin
                     insnRdata <= '0;
                     insnValid <= 1'b1;
                  end else begin
                     dataRdata <= '0;
                     dataValid <= 1'b1;
                  end
               end else begin
                  wd_cnt <= wd_cnt + CNT_W'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench: two arbiters (fixed priority and alternating, watchdog 4)
// driven by random requesters and a random-latency memory, checked against a transaction model.
module tb_mem_port_arbiter;

   localparam int unsigned TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ireq   [2];
   logic [31:0] iaddr  [2];
   logic [31:0] irdata [2];
   logic        ivalid [2];
   logic        istall [2];
   logic        dreq   [2];
   logic        dwe    [2];
   logic [31:0] daddr  [2];
   logic [31:0] dwdata [2];
   logic [31:0] drdata [2];
   logic        dvalid [2];
   logic        dstall [2];
   logic        mreq   [2];
   logic        mwe    [2];
   logic [31:0] maddr  [2];
   logic [31:0] mwdata [2];
   logic [31:0] mrdata [2];
   logic        mack   [2];
   logic        berr   [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_port_arbiter #(
         .ADDR_W(32), .DATA_W(32), .ARB_MODE(g), .TIMEOUT_CYCLES(TMO)
      ) u_dut (
         .clk(clk), .rst(rst_n),
         .insnReq(ireq[g]), .insnAddr(iaddr[g]), .insnRdata(irdata[g]),
         .insnValid(ivalid[g]), .insnStall(istall[g]),
         .dataReq(dreq[g]), .dataWe(dwe[g]), .dataAddr(daddr[g]), .dataWdata(dwdata[g]),
         .dataRdata(drdata[g]), .dataValid(dvalid[g]), .dataStall(dstall[g]),
         .memReq(mreq[g]), .memWe(mwe[g]), .memAddr(maddr[g]), .memWdata(mwdata[g]),
         .memRdata(mrdata[g]), .memAck(mack[g]), .busError(berr[g])
      );
   end

   typedef struct {
      int          due;
      bit          side;    // 1 = data
      logic [31:0] rdata;
      bit          err;
   } exp_t;

   exp_t exp_q [2][$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   // Transaction-level reference state per arbiter.
   bit          m_busy [2];
   int          m_gap  [2];
   bit          m_side [2];
   bit          m_last [2];
   int          m_cnt  [2];
   int          m_lat  [2];
   bit          m_err  [2];
   bit          m_we   [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_wdat [2];
   bit          i_pend [2];
   bit          d_pend [2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[dut%0d] at cycle %0d: got %h, expected %h", name, g, cyc, act, exp);
      end
   endtask

   task automatic model_clear(input int g);
      m_busy[g] = 0; m_gap[g] = 0; m_last[g] = 0; m_err[g] = 0; m_cnt[g] = 0;
      i_pend[g] = 0; d_pend[g] = 0;
      ireq[g] = 0; dreq[g] = 0; dwe[g] = 0; mack[g] = 0;
      exp_q[g].delete();
   endtask

   task automatic chk_reset_outputs(input int g);
      chk("rst_memReq", g, 32'(mreq[g]), 0);
      chk("rst_memWe", g, 32'(mwe[g]), 0);
      chk("rst_memAddr", g, maddr[g], 0);
      chk("rst_memWdata", g, mwdata[g], 0);
      chk("rst_insnValid", g, 32'(ivalid[g]), 0);
      chk("rst_dataValid", g, 32'(dvalid[g]), 0);
      chk("rst_insnRdata", g, irdata[g], 0);
      chk("rst_dataRdata", g, drdata[g], 0);
      chk("rst_busError", g, 32'(berr[g]), 0);
   endtask

   // One negedge of stimulus + memory-side checking for arbiter g.
   task automatic step(input int g, input bit stop_new);
      logic [31:0] r;
      bit          side;
      bit          free;
      chk("memReq", g, 32'(mreq[g]), 32'(m_busy[g]));
      chk("busError", g, 32'(berr[g]), 32'(m_err[g]));
      if (m_busy[g]) begin
         chk("memAddr", g, maddr[g], m_addr[g]);
         chk("memWe", g, 32'(mwe[g]), 32'(m_we[g]));
         if (m_we[g]) chk("memWdata", g, mwdata[g], m_wdat[g]);
      end

      // requesters: retire on valid, occasionally abandon a granted request, issue new ones
      if (ivalid[g]) begin ireq[g] = 0; i_pend[g] = 0; end
      if (dvalid[g]) begin dreq[g] = 0; d_pend[g] = 0; end
      if (m_busy[g] && $urandom_range(0, 15) == 0) begin
         if (m_side[g]) dreq[g] = 0; else ireq[g] = 0;
      end
      if (!stop_new && !i_pend[g] && $urandom_range(0, 2) == 0) begin
         r = $urandom;
         ireq[g] = 1; i_pend[g] = 1; iaddr[g] = r & 32'hFFFF_FFFC;
      end
      if (!stop_new && !d_pend[g] && $urandom_range(0, 2) == 0) begin
         r = $urandom;
         dreq[g] = 1; d_pend[g] = 1; daddr[g] = r & 32'hFFFF_FFFC;
         dwe[g] = ($urandom_range(0, 2) == 0); dwdata[g] = $urandom;
      end

      // memory: random latency 1..5 cycles, 5 means it never answers
      mack[g]   = 0;
      mrdata[g] = $urandom;
      if (m_busy[g]) begin
         m_cnt[g]++;
         if (m_cnt[g] == m_lat[g]) begin
            mack[g] = 1;
            exp_q[g].push_back('{cyc + 1, m_side[g], (m_side[g] && m_we[g]) ? 32'h0 : mrdata[g], m_err[g]});
            m_busy[g] = 0; m_gap[g] = 2;
         end else if (m_cnt[g] == int'(TMO)) begin
            m_err[g] = 1;
            exp_q[g].push_back('{cyc + 1, m_side[g], 32'h0, 1'b1});
            m_busy[g] = 0; m_gap[g] = 2;
         end
      end else if ($urandom_range(0, 7) == 0) begin
         mack[g] = 1;
      end

      // grant: the completion edge and the valid cycle's edge are not grant points
      free = 0;
      if (!m_busy[g]) begin
         if (m_gap[g] > 0) m_gap[g]--;
         else free = 1;
      end
      if (free && (ireq[g] || dreq[g])) begin
         if (ireq[g] && dreq[g]) side = (g == 0) ? 1'b1 : !m_last[g];
         else side = dreq[g];
         m_busy[g] = 1; m_cnt[g] = 0; m_lat[g] = $urandom_range(1, 5);
         m_side[g] = side; m_last[g] = side;
         m_addr[g] = side ? daddr[g] : iaddr[g];
         m_we[g]   = side ? dwe[g] : 1'b0;
         m_wdat[g] = dwdata[g];
      end
   endtask

   // Core-side monitor: compares completion pulses against the scoreboard.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rst_n) begin
            for (int g = 0; g < 2; g++) begin
               if (exp_q[g].size() > 0 && exp_q[g][0].due == cyc) begin
                  exp_t e;
                  e = exp_q[g].pop_front();
                  chk("insnValid", g, 32'(ivalid[g]), 32'(!e.side));
                  chk("dataValid", g, 32'(dvalid[g]), 32'(e.side));
                  chk(e.side ? "dataRdata" : "insnRdata", g, e.side ? drdata[g] : irdata[g], e.rdata);
                  chk("busError_at_valid", g, 32'(berr[g]), 32'(e.err));
               end else begin
                  chk("idle_insnValid", g, 32'(ivalid[g]), 0);
                  chk("idle_dataValid", g, 32'(dvalid[g]), 0);
               end
               chk("insnStall", g, 32'(istall[g]), 32'(ireq[g] && !ivalid[g]));
               chk("dataStall", g, 32'(dstall[g]), 32'(dreq[g] && !dvalid[g]));
            end
         end
      end
   end

   initial begin
      int armed;
      rst_n = 0;
      armed = -1;
      for (int g = 0; g < 2; g++) begin
         model_clear(g);
         iaddr[g] = 0; daddr[g] = 0; dwdata[g] = 0; mrdata[g] = 0;
      end
      repeat (3) @(negedge clk);
      for (int g = 0; g < 2; g++) chk_reset_outputs(g);
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (c == 0) rst_n = 1;
         if (c == 1300 || c == 2600) armed = 0;
         if (armed >= 0) begin
            armed++;
            if ((m_busy[0] && !m_side[0] && m_cnt[0] >= 1) || armed > 200) begin
               rst_n = 0;
               #1;
               for (int g = 0; g < 2; g++) begin
                  chk_reset_outputs(g);
                  model_clear(g);
               end
               repeat (2) @(negedge clk);
               rst_n = 1;
               armed = -1;
            end
         end
         for (int g = 0; g < 2; g++) step(g, c > 3950);
      end
      for (int g = 0; g < 2; g++) begin
         chk("pending_at_end", g, 32'(exp_q[g].size()), 0);
         chk("busy_at_end", g, 32'(m_busy[g]), 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
